// File: rtl/demux4_tdm.sv
`default_nettype none
// ============================================================================
// Module      : demux4_tdm
// Description : Receive-side 1:4 TDM demultiplexer. A serial stream carries
//               one bit per enabled cycle, slot k holding bit k of a 4-bit
//               word, with a frame marker on slot 0. The block hunts for the
//               marker, then reassembles each word and publishes it on Out.
//               A word that ends without a clean frame marker is dropped and
//               flagged.
//
// Ports       : clk      - rising-edge clock
//               rst      - asynchronous active-high reset
//               en       - slot-advance enable (0 = hold all state)
//               frame    - frame marker, 1 on the slot-0 cycle
//               din      - serial TDM data
//               S        - slot index expected at the next enabled edge
//               Out      - last complete word, Out[k] = bit of slot k
//               valid    - one-cycle strobe, Out updated at preceding edge
//               locked   - 1 while frame-aligned (LOCKED state)
//               sync_err - one-cycle strobe on a frame-alignment violation
//
// Revision    : 1.0 - initial release
// ============================================================================
module demux4_tdm (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       frame,
    input  logic       din,
    output logic [1:0] S,
    output logic [3:0] Out,
    output logic       valid,
    output logic       locked,
    output logic       sync_err
);

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    localparam logic [0:0] c_HUNT      = 1'b0;
    localparam logic [0:0] c_LOCKED    = 1'b1;
    localparam logic [1:0] c_FIRST_SLOT = 2'd0;
    localparam logic [1:0] c_LAST_SLOT  = 2'd3;

    // ------------------------------------------------------------------------
    // Registers and next-state wires
    // ------------------------------------------------------------------------
    logic [0:0] r_state;
    logic [1:0] r_s;
    logic [3:0] r_asm;
    logic [3:0] r_out;
    logic       r_valid;
    logic       r_sync_err;

    logic [0:0] w_state_nxt;
    logic [1:0] w_s_nxt;
    logic [3:0] w_asm_nxt;
    logic [3:0] w_out_nxt;
    logic       w_valid_nxt;
    logic       w_sync_err_nxt;

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= c_HUNT;
            r_s        <= c_FIRST_SLOT;
            r_asm      <= 4'h0;
            r_out      <= 4'h0;
            r_valid    <= 1'b0;
            r_sync_err <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_s        <= w_s_nxt;
            r_asm      <= w_asm_nxt;
            r_out      <= w_out_nxt;
            r_valid    <= w_valid_nxt;
            r_sync_err <= w_sync_err_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state and strobe logic
    // Strobes default to 0 so that every event produces a single-cycle pulse
    // and an idle (en=0) cycle clears any pulse from the previous edge.
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt    = r_state;
        w_s_nxt        = r_s;
        w_asm_nxt      = r_asm;
        w_out_nxt      = r_out;
        w_valid_nxt    = 1'b0;
        w_sync_err_nxt = 1'b0;

        if (en) begin
            case (r_state)
                c_HUNT: begin
                    if (frame) begin
                        // Marker found: this cycle already carries slot 0.
                        w_state_nxt = c_LOCKED;
                        w_asm_nxt   = {3'b000, din};
                        w_s_nxt     = 2'd1;
                    end else begin
                        w_s_nxt = c_FIRST_SLOT;
                    end
                end

                c_LOCKED: begin
                    if (frame) begin
                        // A marker anywhere but slot 0 abandons the partial
                        // word and realigns on this cycle as slot 0.
                        w_sync_err_nxt = (r_s != c_FIRST_SLOT);
                        w_asm_nxt      = {3'b000, din};
                        w_s_nxt        = 2'd1;
                    end else if (r_s == c_FIRST_SLOT) begin
                        // Marker missing where one was due: alignment lost.
                        w_sync_err_nxt = 1'b1;
                        w_state_nxt    = c_HUNT;
                        w_asm_nxt      = 4'h0;
                        w_s_nxt        = c_FIRST_SLOT;
                    end else if (r_s == c_LAST_SLOT) begin
                        // Final slot: publish the whole word in one step so
                        // Out is never seen partially updated.
                        w_out_nxt   = {din, r_asm[2:0]};
                        w_valid_nxt = 1'b1;
                        w_asm_nxt   = 4'h0;
                        w_s_nxt     = c_FIRST_SLOT;
                    end else begin
                        w_asm_nxt[r_s] = din;
                        w_s_nxt        = r_s + 2'd1;
                    end
                end

                default: begin
                    w_state_nxt = c_HUNT;
                    w_asm_nxt   = 4'h0;
                    w_s_nxt     = c_FIRST_SLOT;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Outputs come straight from registers
    // ------------------------------------------------------------------------
    assign S        = r_s;
    assign Out      = r_out;
    assign valid    = r_valid;
    assign locked   = (r_state == c_LOCKED);
    assign sync_err = r_sync_err;

endmodule
`default_nettype wire

// File: tb/tb_demux4_tdm.sv
`default_nettype none
// ============================================================================
// Module      : tb_demux4_tdm
// Description : Self-checking bench for demux4_tdm. A fixed vector table
//               covers lock-up and back-to-back words, hand sequences cover
//               early/missing frames, enable stalls and mid-word reset, and
//               a random run is checked against a word-level reference model
//               that collects slot bits in a queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_demux4_tdm;

    logic       clk;
    logic       rst;
    logic       en;
    logic       frame;
    logic       din;
    logic [1:0] S;
    logic [3:0] Out;
    logic       valid;
    logic       locked;
    logic       sync_err;

    demux4_tdm u_dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .frame    (frame),
        .din      (din),
        .S        (S),
        .Out      (Out),
        .valid    (valid),
        .locked   (locked),
        .sync_err (sync_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // ------------------------------------------------------------------------
    // Reference model: bits of the word in progress, oldest first.
    // ------------------------------------------------------------------------
    bit       m_locked;
    bit       m_bits[$];
    bit [3:0] m_out;
    bit       m_valid;
    bit       m_serr;

    task automatic model_reset();
        m_locked = 1'b0;
        m_bits.delete();
        m_out    = 4'h0;
        m_valid  = 1'b0;
        m_serr   = 1'b0;
    endtask

    task automatic model_step(input bit e, input bit f, input bit d);
        m_valid = 1'b0;
        m_serr  = 1'b0;
        if (e) begin
            if (!m_locked) begin
                if (f) begin
                    m_locked = 1'b1;
                    m_bits.delete();
                    m_bits.push_back(d);
                end
            end else if (f) begin
                if (m_bits.size() != 0) m_serr = 1'b1;
                m_bits.delete();
                m_bits.push_back(d);
            end else if (m_bits.size() == 0) begin
                m_serr   = 1'b1;
                m_locked = 1'b0;
            end else begin
                m_bits.push_back(d);
                if (m_bits.size() == 4) begin
                    for (int k = 0; k < 4; k++) m_out[k] = m_bits[k];
                    m_valid = 1'b1;
                    m_bits.delete();
                end
            end
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_model(input string name);
        chk({name, ".S"},        32'(S),        32'(m_bits.size()));
        chk({name, ".Out"},      32'(Out),      32'(m_out));
        chk({name, ".valid"},    32'(valid),    32'(m_valid));
        chk({name, ".locked"},   32'(locked),   32'(m_locked));
        chk({name, ".sync_err"}, 32'(sync_err), 32'(m_serr));
        chk({name, ".excl"},     32'(valid & sync_err), 32'd0);
    endtask

    // Drive one cycle, advance the model and compare just after the edge.
    task automatic step(input string name, input bit e, input bit f, input bit d);
        en    = e;
        frame = f;
        din   = d;
        @(posedge clk);
        #1;
        model_step(e, f, d);
        check_model(name);
    endtask

    // ------------------------------------------------------------------------
    // Vector table
    // ------------------------------------------------------------------------
    typedef struct {
        bit       e, f, d;
        bit [1:0] s;
        bit [3:0] o;
        bit       v, l, se;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input bit e, input bit f, input bit d, input bit [1:0] s,
                       input bit [3:0] o, input bit v, input bit l, input bit se);
        vec_t r;
        r.e = e; r.f = f; r.d = d; r.s = s; r.o = o; r.v = v; r.l = l; r.se = se;
        tbl.push_back(r);
    endtask

    initial begin
        bit e, f, d;

        rst = 1'b1; en = 1'b0; frame = 1'b0; din = 1'b0;
        model_reset();
        #12;
        check_model("reset");

        // Lock on frame with din=0, then 1,1,1 -> 4'hE.
        add(1,1,0, 2'd1, 4'h0, 0,1,0);
        add(1,0,1, 2'd2, 4'h0, 0,1,0);
        add(1,0,1, 2'd3, 4'h0, 0,1,0);
        add(1,0,1, 2'd0, 4'hE, 1,1,0);
        // Back-to-back words A, C, B, 0 (LSB first).
        add(1,1,0, 2'd1, 4'hE, 0,1,0);
        add(1,0,1, 2'd2, 4'hE, 0,1,0);
        add(1,0,0, 2'd3, 4'hE, 0,1,0);
        add(1,0,1, 2'd0, 4'hA, 1,1,0);
        add(1,1,0, 2'd1, 4'hA, 0,1,0);
        add(1,0,0, 2'd2, 4'hA, 0,1,0);
        add(1,0,1, 2'd3, 4'hA, 0,1,0);
        add(1,0,1, 2'd0, 4'hC, 1,1,0);
        add(1,1,1, 2'd1, 4'hC, 0,1,0);
        add(1,0,1, 2'd2, 4'hC, 0,1,0);
        add(1,0,0, 2'd3, 4'hC, 0,1,0);
        add(1,0,1, 2'd0, 4'hB, 1,1,0);
        add(1,1,0, 2'd1, 4'hB, 0,1,0);
        add(1,0,0, 2'd2, 4'hB, 0,1,0);
        add(1,0,0, 2'd3, 4'hB, 0,1,0);
        add(1,0,0, 2'd0, 4'h0, 1,1,0);

        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            step($sformatf("vec%0d", i), tbl[i].e, tbl[i].f, tbl[i].d);
            chk($sformatf("vec%0d.S", i),        32'(S),        32'(tbl[i].s));
            chk($sformatf("vec%0d.Out", i),      32'(Out),      32'(tbl[i].o));
            chk($sformatf("vec%0d.valid", i),    32'(valid),    32'(tbl[i].v));
            chk($sformatf("vec%0d.locked", i),   32'(locked),   32'(tbl[i].l));
            chk($sformatf("vec%0d.sync_err", i), 32'(sync_err), 32'(tbl[i].se));
        end

        // Early frame at S=2: realign, then bits 1,0,1 complete 4'hB.
        step("early0", 1, 1, 1);
        step("early1", 1, 0, 0);
        step("early2", 1, 1, 1);
        chk("early.serr", 32'(sync_err), 32'd1);
        chk("early.S",    32'(S),        32'd1);
        chk("early.val",  32'(valid),    32'd0);
        step("early3", 1, 0, 1);
        chk("early.pulse", 32'(sync_err), 32'd0);
        step("early4", 1, 0, 0);
        step("early5", 1, 0, 1);
        chk("early.Out", 32'(Out), 32'hB);
        chk("early.v",   32'(valid), 32'd1);

        // Missing frame at S=0: drop lock, ignore traffic until a marker.
        step("miss0", 1, 0, 1);
        chk("miss.serr",   32'(sync_err), 32'd1);
        chk("miss.locked", 32'(locked),   32'd0);
        chk("miss.Out",    32'(Out),      32'hB);
        for (int i = 0; i < 6; i++) step("hunt", 1, 0, i[0]);
        chk("hunt.locked", 32'(locked), 32'd0);

        // Word 4'h5 with a 3-cycle enable stall between slots 1 and 2.
        step("stall0", 1, 1, 1);
        step("stall1", 1, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step("stall_hold", 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            chk("stall.S", 32'(S), 32'd2);
        end
        step("stall2", 1, 0, 1);
        step("stall3", 1, 0, 0);
        chk("stall.Out", 32'(Out),   32'h5);
        chk("stall.v",   32'(valid), 32'd1);

        // Asynchronous reset pulsed between edges at S=2, then word 4'h9.
        step("ar0", 1, 1, 1);
        step("ar1", 1, 0, 1);
        #2 rst = 1'b1;
        #1;
        chk("ar.S",      32'(S),        32'd0);
        chk("ar.Out",    32'(Out),      32'h0);
        chk("ar.valid",  32'(valid),    32'd0);
        chk("ar.locked", 32'(locked),   32'd0);
        chk("ar.serr",   32'(sync_err), 32'd0);
        model_reset();
        #1 rst = 1'b0;
        step("ar2", 1, 0, 1);
        chk("ar.nolock", 32'(locked), 32'd0);
        step("ar3", 1, 1, 1);
        step("ar4", 1, 0, 0);
        step("ar5", 1, 0, 0);
        step("ar6", 1, 0, 1);
        chk("ar.Out9", 32'(Out), 32'h9);

        // Random traffic: mostly well-aligned frames with occasional faults.
        for (int i = 0; i < 400; i++) begin
            e = ($urandom_range(0, 4) != 0);
            if (m_bits.size() == 0) f = ($urandom_range(0, 9) != 0);
            else                    f = ($urandom_range(0, 11) == 0);
            d = 1'($urandom_range(0, 1));
            step("rand", e, f, d);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/demux4_tdm.md
DEMUX4_TDM -- requirements
Module: demux4_tdm

Interface
REQ-001 clk  input  1  Single clock; all state changes on its rising edge.
REQ-002 rst  input  1  Asynchronous, active-high reset.
REQ-003 en  input  1  Slot-advance enable; when 0 the block holds all state.
REQ-004 frame  input  1  Frame marker; 1 marks the cycle carrying slot 0.
REQ-005 din  input  1  Serial TDM data; one bit per enabled cycle, slot k carries bit k.
REQ-006 S  output  2  Slot index expected at the next enabled edge (0..3).
REQ-007 Out  output  4  Last complete reassembled word; Out[k] equals the bit received in slot k.
REQ-008 valid  output  1  One-cycle strobe; Out was updated at the preceding edge.
REQ-009 locked  output  1  1 while in LOCKED state.
REQ-010 sync_err  output  1  One-cycle strobe flagging a frame-alignment violation.

Function
REQ-011 The block SHALL be the receive-side inverse of the 4:1 select-mux path: each enabled cycle routes din to bit S of an internal 4-bit assembly register.
REQ-012 States SHALL be HUNT and LOCKED; S is a 2-bit counter that wraps 3->0.
REQ-013 en=0: S, state, assembly register and Out hold; valid and sync_err are 0 in the following cycle; frame and din are ignored.
REQ-014 HUNT, en=1, frame=0: din discarded, S stays 0, no strobes.
REQ-015 HUNT, en=1, frame=1: din captured into assembly bit 0, S->1, state->LOCKED.
REQ-016 LOCKED, en=1, S=0, frame=1: din captured into bit 0, S->1.
REQ-017 LOCKED, en=1, S in 1..2, frame=0: din captured into bit S, S increments.
REQ-018 LOCKED, en=1, S=3, frame=0: Out <= {din, assembly[2:0]}, valid=1 for exactly the next cycle, S->0.
REQ-019 LOCKED, en=1, S!=0, frame=1 (early frame): partial word discarded, no valid, sync_err=1 for one cycle, din captured into bit 0, S->1, stay LOCKED.
REQ-020 LOCKED, en=1, S=0, frame=0 (missing frame): din discarded, sync_err=1 for one cycle, state->HUNT, S stays 0.
REQ-021 valid and sync_err SHALL never both be 1 in the same cycle; each is a single-cycle pulse per event.
REQ-022 Out SHALL change only on a REQ-018 edge or on reset; it is never partially updated.
REQ-023 All outputs SHALL be driven directly from registers (no combinational path from inputs to outputs).
REQ-024 The assembly register SHALL be cleared whenever a word is discarded (REQ-019, REQ-020) or completed (REQ-018).

Reset
REQ-025 rst=1 SHALL immediately, without waiting for clk, force state=HUNT, S=0, Out=4'h0, assembly=4'h0, valid=0, locked=0, sync_err=0.
REQ-026 Reset asserted mid-word SHALL discard the partial word with no valid and no sync_err; after release, the first word requires a new frame marker.
REQ-027 Inputs SHALL be ignored while rst=1; the first edge after release is evaluated as a HUNT cycle.

Verification
REQ-028 Reset, en=1; frame=1 with din=0, then din=1,1,1 (frame=0) -> locked=1 after 1st edge; Out=4'hE, valid=1 one cycle after 4th edge; S=0.
REQ-029 Back-to-back frames with words 4'hA, 4'hC, 4'hB, 4'h0 (LSB first, frame on each slot 0) -> Out sequence A, C, B, 0; exactly four valid pulses spaced 4 cycles; sync_err never 1.
REQ-030 Locked, frame=1 arriving at S=2 -> sync_err pulse, no valid, S=1 next; following three bits 1,0,1 complete word with bit0 from the early-frame cycle; Out updated accordingly.
REQ-031 Locked, frame=0 at S=0 -> sync_err pulse, locked=0, Out unchanged; din toggling without frame produces no valid until frame=1.
REQ-032 en deasserted for 3 cycles between slots 1 and 2 of word 4'h5 -> S, Out held, no strobes; Out=4'h5 with valid after the remaining slots complete.
REQ-033 rst pulsed between clock edges at S=2 -> all outputs zero immediately, no valid; subsequent frame-aligned 4'h9 yields Out=4'h9.
